// File: rtl/ddr5_ctrl_pkg.sv
// Shared constants and types for the simplified x16 DDR5 controller core.
// Holds CA opcodes, address field widths and the scheduler state encoding.
package ddr5_ctrl_pkg;

  localparam int ROW_W = 12;
  localparam int COL_W = 10;
  localparam int CA_W  = 14;

  localparam logic [1:0] OP_ACT = 2'b00;
  localparam logic [3:0] OP_WR  = 4'b0100;
  localparam logic [3:0] OP_RD  = 4'b0101;
  localparam logic [3:0] OP_PRE = 4'b0110;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ACT       = 3'd1,
    ST_TRCD_WAIT = 3'd2,
    ST_CMD       = 3'd3,
    ST_DATA      = 3'd4,
    ST_PRE       = 3'd5,
    ST_TRP_WAIT  = 3'd6
  } state_e;

  // Only the low 16 MiB of the byte address space maps onto the device.
  function automatic logic addr_ok(input logic [7:0] addr_hi);
    return (addr_hi == 8'h00);
  endfunction

endpackage

// File: rtl/ddr5_ctrl_core_fifo.sv
// Synchronous FIFO with full/empty flags; a push and a pop may share a cycle.
// Storage is not reset: consumers gate the head entry with the empty flag.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push_s, do_pop_s;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer, occupancy and storage update.
  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    mem_d     = mem_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (do_push_s && !do_pop_s) begin
      cnt_d = cnt_q + {{AW{1'b0}}, 1'b1};
    end else if (do_pop_s && !do_push_s) begin
      cnt_d = cnt_q - {{AW{1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ddr5_ctrl_core.sv
// Request FIFOs plus a closed-page command sequencer for one x16 DDR5 channel.
// Each accepted request becomes ACT / WR|RD / PRE with registered CA, CS and DQ.
module ddr5_ctrl_core
  import ddr5_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TRCD       = 2,
  parameter int TWL        = 2,
  parameter int TRL        = 3,
  parameter int TRP        = 2
) (
  input  logic        mem_clk,
  input  logic        rst_n,
  input  logic        W_Valid,
  input  logic [31:0] W_Data,
  input  logic [3:0]  W_STRB,
  input  logic [31:0] W_Address,
  output logic        W_Ready,
  input  logic        R_Valid_Address,
  input  logic [31:0] R_Address,
  output logic        R_Ready_Address,
  output logic [31:0] R_Data,
  output logic        R_Valid,
  input  logic        R_Ready,
  output logic        R_Error,
  inout  wire  [15:0] DQ,
  output logic [13:0] CA,
  output logic        CS
);

  localparam logic [3:0] TRCD_LAST = 4'(TRCD - 2);
  localparam logic [3:0] TWL_C     = 4'(TWL);
  localparam logic [3:0] TRL_C     = 4'(TRL);
  localparam logic [3:0] TRP_LAST  = 4'(TRP - 1);

  logic        wf_full_s, wf_empty_s, wf_pop_s;
  logic [65:0] wf_rdata_s;
  logic        raf_full_s, raf_empty_s, raf_pop_s;
  logic [31:0] raf_rdata_s;
  logic        rdf_full_s, rdf_empty_s, rdf_push_s, rdf_pop_s;
  logic [32:0] rdf_din_s, rdf_rdata_s;
  logic        unused_s;

  // Write entry drops addr[1:0]: {addr[31:2], data, strobe}.
  logic [29:0] wf_addr_s;
  logic [31:0] wf_data_s;
  logic [3:0]  wf_strb_s;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              is_wr_q, is_wr_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [15:0]       rlo_q, rlo_d;
  logic              cs_q, cs_d;
  logic [CA_W-1:0]   ca_q, ca_d;
  logic              dq_oe_q, dq_oe_d;
  logic [15:0]       dq_out_q, dq_out_d;
  logic [3:0]        lat_s;

  sync_fifo #(.WIDTH(66), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk(mem_clk), .rst_n(rst_n),
    .push(W_Valid), .push_data({W_Address[31:2], W_Data, W_STRB}),
    .pop(wf_pop_s), .pop_data(wf_rdata_s),
    .full(wf_full_s), .empty(wf_empty_s)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_raddr_fifo (
    .clk(mem_clk), .rst_n(rst_n),
    .push(R_Valid_Address), .push_data(R_Address),
    .pop(raf_pop_s), .pop_data(raf_rdata_s),
    .full(raf_full_s), .empty(raf_empty_s)
  );

  sync_fifo #(.WIDTH(33), .DEPTH(FIFO_DEPTH)) u_rdata_fifo (
    .clk(mem_clk), .rst_n(rst_n),
    .push(rdf_push_s), .push_data(rdf_din_s),
    .pop(rdf_pop_s), .pop_data(rdf_rdata_s),
    .full(rdf_full_s), .empty(rdf_empty_s)
  );

  assign wf_addr_s       = wf_rdata_s[65:36];
  assign wf_data_s       = wf_rdata_s[35:4];
  assign wf_strb_s       = wf_rdata_s[3:0];
  assign unused_s        = ^{W_Address[1:0], raf_rdata_s[1:0]};
  assign W_Ready         = !wf_full_s;
  assign R_Ready_Address = !raf_full_s;
  assign R_Valid         = !rdf_empty_s;
  assign rdf_pop_s       = R_Valid && R_Ready;
  assign R_Data          = rdf_empty_s ? 32'h0000_0000 : rdf_rdata_s[31:0];
  assign R_Error         = rdf_empty_s ? 1'b0 : rdf_rdata_s[32];
  assign CS              = cs_q;
  assign CA              = ca_q;
  assign DQ              = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign lat_s           = is_wr_q ? TWL_C : TRL_C;

  // Scheduler next state, FIFO control and next-cycle bus values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_wr_d    = is_wr_q;
    row_d      = row_q;
    col_d      = col_q;
    wdata_d    = wdata_q;
    rlo_d      = rlo_q;
    wf_pop_s   = 1'b0;
    raf_pop_s  = 1'b0;
    rdf_push_s = 1'b0;
    rdf_din_s  = 33'h0_0000_0000;
    cs_d       = 1'b1;
    ca_d       = 14'h0000;
    dq_oe_d    = 1'b0;
    dq_out_d   = 16'h0000;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (!wf_empty_s) begin
          wf_pop_s = 1'b1;
          if ((wf_strb_s == 4'hF) && addr_ok(wf_addr_s[29:22])) begin
            state_d = ST_ACT;
            is_wr_d = 1'b1;
            row_d   = wf_addr_s[21:10];
            col_d   = wf_addr_s[9:0];
            wdata_d = wf_data_s;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!raf_empty_s && !rdf_full_s) begin
          raf_pop_s = 1'b1;
          if (addr_ok(raf_rdata_s[31:24])) begin
            state_d = ST_ACT;
            is_wr_d = 1'b0;
            row_d   = raf_rdata_s[23:12];
            col_d   = raf_rdata_s[11:2];
          end else begin
            rdf_push_s = 1'b1;
            rdf_din_s  = {1'b1, 32'h0000_0000};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACT: begin
        cnt_d = 4'd0;
        if (TRCD > 1) begin
          state_d = ST_TRCD_WAIT;
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_TRCD_WAIT: begin
        if (cnt_q == TRCD_LAST) begin
          state_d = ST_CMD;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_CMD: begin
        state_d = ST_DATA;
        cnt_d   = 4'd0;
      end
      ST_DATA: begin
        // Burst occupies lat+1 cycles: lat-1 of latency, then two beats.
        if (!is_wr_q && (cnt_q == TRL_C - 4'd1)) begin
          rlo_d = DQ;
        end else begin
          rlo_d = rlo_q;
        end
        if (cnt_q == lat_s) begin
          state_d = ST_PRE;
          cnt_d   = 4'd0;
          if (!is_wr_q) begin
            rdf_push_s = 1'b1;
            rdf_din_s  = {1'b0, DQ, rlo_q};
          end else begin
            rdf_push_s = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_PRE: begin
        state_d = ST_TRP_WAIT;
        cnt_d   = 4'd0;
      end
      ST_TRP_WAIT: begin
        if (cnt_q == TRP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Bus values are registered so they line up with the state being entered.
    case (state_d)
      ST_ACT: begin
        cs_d = 1'b0;
        ca_d = {OP_ACT, row_d};
      end
      ST_CMD: begin
        cs_d = 1'b0;
        ca_d = is_wr_d ? {OP_WR, col_d} : {OP_RD, col_d};
      end
      ST_PRE: begin
        cs_d = 1'b0;
        ca_d = {OP_PRE, 10'h000};
      end
      ST_DATA: begin
        if (is_wr_d && (cnt_d == TWL_C - 4'd1)) begin
          dq_oe_d  = 1'b1;
          dq_out_d = wdata_d[15:0];
        end else if (is_wr_d && (cnt_d == TWL_C)) begin
          dq_oe_d  = 1'b1;
          dq_out_d = wdata_d[31:16];
        end else begin
          dq_oe_d = 1'b0;
        end
      end
      default: begin
        cs_d = 1'b1;
      end
    endcase
  end

  // Sequencer and bus registers; reset abandons any sequence in flight.
  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      is_wr_q  <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      wdata_q  <= 32'h0000_0000;
      rlo_q    <= 16'h0000;
      cs_q     <= 1'b1;
      ca_q     <= 14'h0000;
      dq_oe_q  <= 1'b0;
      dq_out_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_wr_q  <= is_wr_d;
      row_q    <= row_d;
      col_q    <= col_d;
      wdata_q  <= wdata_d;
      rlo_q    <= rlo_d;
      cs_q     <= cs_d;
      ca_q     <= ca_d;
      dq_oe_q  <= dq_oe_d;
      dq_out_q <= dq_out_d;
    end
  end

endmodule

// File: tb/tb_ddr5_ctrl_core.sv
// Directed bench for ddr5_ctrl_core with a small behavioural DRAM on DQ/CA/CS.
// Commands and DUT-driven DQ beats are logged on the falling edge for checking.
module tb_ddr5_ctrl_core;

  localparam int TRCD = 2;
  localparam int TWL  = 2;
  localparam int TRL  = 3;
  localparam int TRP  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        W_Valid, R_Valid_Address, R_Ready;
  logic [31:0] W_Data, W_Address, R_Address;
  logic [3:0]  W_STRB;
  logic        W_Ready, R_Ready_Address, R_Valid, R_Error, CS;
  logic [31:0] R_Data;
  logic [13:0] CA;
  wire  [15:0] dq;

  int total = 0;
  int bad   = 0;

  logic [15:0] dq_m = 16'h0000;
  logic        dq_oe_m = 1'b0;
  assign dq = dq_oe_m ? dq_m : 16'hzzzz;

  ddr5_ctrl_core #(.FIFO_DEPTH(4), .TRCD(TRCD), .TWL(TWL), .TRL(TRL), .TRP(TRP)) dut (
    .mem_clk(clk), .rst_n(rst_n),
    .W_Valid(W_Valid), .W_Data(W_Data), .W_STRB(W_STRB), .W_Address(W_Address),
    .W_Ready(W_Ready),
    .R_Valid_Address(R_Valid_Address), .R_Address(R_Address),
    .R_Ready_Address(R_Ready_Address),
    .R_Data(R_Data), .R_Valid(R_Valid), .R_Ready(R_Ready), .R_Error(R_Error),
    .DQ(dq), .CA(CA), .CS(CS)
  );

  always #5 clk = ~clk;

  // DRAM model and bus logger
  int          cyc = 0;
  int          wr_at = 0, rd_at = 0;
  logic [11:0] row_m = 12'h000;
  logic [21:0] wkey, rkey;
  logic [15:0] wlo;
  logic [31:0] mem_m [logic [21:0]];
  logic [13:0] cmd_v [$];
  int          cmd_c [$];
  logic [15:0] beat_v [$];
  int          beat_c [$];

  always @(negedge clk) begin
    cyc++;
    if (!dq_oe_m && (dq !== 16'hzzzz)) begin
      beat_v.push_back(dq);
      beat_c.push_back(cyc);
    end
    if (wr_at != 0 && cyc == wr_at) wlo = dq;
    if (wr_at != 0 && cyc == wr_at + 1) begin
      mem_m[wkey] = {dq, wlo};
      wr_at = 0;
    end
    if (rd_at != 0 && cyc == rd_at) begin
      dq_m = mem_m.exists(rkey) ? mem_m[rkey][15:0] : 16'h0000;
      dq_oe_m = 1'b1;
    end else if (rd_at != 0 && cyc == rd_at + 1) begin
      dq_m = mem_m.exists(rkey) ? mem_m[rkey][31:16] : 16'h0000;
    end else if (rd_at != 0 && cyc == rd_at + 2) begin
      dq_oe_m = 1'b0;
      rd_at = 0;
    end
    if (CS === 1'b0) begin
      cmd_v.push_back(CA);
      cmd_c.push_back(cyc);
      case (CA[13:10])
        4'b0100: begin wr_at = cyc + TWL; wkey = {row_m, CA[9:0]}; end
        4'b0101: begin rd_at = cyc + TRL; rkey = {row_m, CA[9:0]}; end
        default: if (CA[13:12] == 2'b00) row_m = CA[11:0];
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    cmd_v.delete(); cmd_c.delete(); beat_v.delete(); beat_c.delete();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic ok;
    ok = 1'b0;
    W_Valid = 1'b1; W_Address = a; W_Data = d; W_STRB = s;
    for (int i = 0; i < 300; i++) begin
      if (W_Ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    W_Valid = 1'b0;
    chk("wr_accept", ok, 1);
  endtask

  task automatic rd_push(input logic [31:0] a);
    logic ok;
    ok = 1'b0;
    R_Valid_Address = 1'b1; R_Address = a;
    for (int i = 0; i < 300; i++) begin
      if (R_Ready_Address === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    R_Valid_Address = 1'b0;
    chk("rd_accept", ok, 1);
  endtask

  // Checks one ACT/WR/PRE triplet at cmd index ci and its two beats at beat index bi.
  task automatic chk_write(input string tg, input int ci, input int bi, input logic [13:0] act,
                           input logic [13:0] wr, input logic [15:0] lo, input logic [15:0] hi);
    if (cmd_v.size() >= ci + 3 && beat_v.size() >= bi + 2) begin
      chk({tg, "_act"}, cmd_v[ci], act);
      chk({tg, "_wr"}, cmd_v[ci+1], wr);
      chk({tg, "_pre"}, cmd_v[ci+2], 14'h1800);
      chk({tg, "_trcd"}, cmd_c[ci+1] - cmd_c[ci], TRCD);
      chk({tg, "_lo"}, beat_v[bi], lo);
      chk({tg, "_hi"}, beat_v[bi+1], hi);
      chk({tg, "_twl"}, beat_c[bi] - cmd_c[ci+1], TWL);
      chk({tg, "_beat2"}, beat_c[bi+1] - beat_c[bi], 1);
      chk({tg, "_pre_t"}, cmd_c[ci+2] - beat_c[bi+1], 1);
    end else begin
      chk({tg, "_logsize"}, {cmd_v.size() >= ci + 3, beat_v.size() >= bi + 2}, 2'b11);
    end
  endtask

  task automatic chk_read(input string tg, input logic [13:0] rd, input logic [31:0] d);
    chk({tg, "_ncmd"}, cmd_v.size(), 3);
    if (cmd_v.size() == 3) begin
      chk({tg, "_act"}, cmd_v[0], 14'h0004);
      chk({tg, "_rd"}, cmd_v[1], rd);
      chk({tg, "_pre"}, cmd_v[2], 14'h1800);
    end else begin
      chk({tg, "_cmds"}, cmd_v.size(), 3);
    end
    chk({tg, "_nodrive"}, beat_v.size(), 0);
    chk({tg, "_valid"}, R_Valid, 1);
    chk({tg, "_data"}, R_Data, d);
    chk({tg, "_err"}, R_Error, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    rst_n = 1'b0; W_Valid = 1'b0; R_Valid_Address = 1'b0; R_Ready = 1'b0;
    W_Data = 32'h0; W_Address = 32'h0; W_STRB = 4'h0; R_Address = 32'h0;
    wait_cyc(3);
    chk("rst_cs", CS, 1);
    chk("rst_ca", CA, 0);
    chk("rst_dq_z", (dq === 16'hzzzz), 1);
    chk("rst_rvalid", R_Valid, 0);
    chk("rst_rdata", R_Data, 0);
    chk("rst_rerror", R_Error, 0);
    chk("rst_wready", W_Ready, 1);
    chk("rst_raready", R_Ready_Address, 1);
    rst_n = 1'b1;
    wait_cyc(2);
    clr();

    // Write 1: ACT must appear in the cycle right after the accepting edge.
    wr_push(32'h0000_4567, 32'h1425_3679, 4'hF);
    @(negedge clk);
    chk("act_latency_cs", CS, 0);
    chk("act_latency_ca", CA, 14'h0004);
    wait_cyc(14);
    chk_write("w1", 0, 0, 14'h0004, 14'h1159, 16'h3679, 16'h1425);
    clr();

    wr_push(32'h0000_4823, 32'h5148_AECF, 4'hF);
    wait_cyc(14);
    chk_write("w2", 0, 0, 14'h0004, 14'h1208, 16'hAECF, 16'h5148);
    clr();

    // Read back, hold while R_Ready is low, then pop.
    rd_push(32'h0000_4567);
    wait_cyc(14);
    chk_read("r1", 14'h1559, 32'h1425_3679);
    wait_cyc(3);
    chk("r1_hold", R_Data, 32'h1425_3679);
    R_Ready = 1'b1;
    @(negedge clk);
    R_Ready = 1'b0;
    chk("r1_pop", R_Valid, 0);
    clr();

    rd_push(32'h0000_4823);
    wait_cyc(14);
    chk_read("r2", 14'h1608, 32'h5148_AECF);
    R_Ready = 1'b1;
    @(negedge clk);
    R_Ready = 1'b0;
    clr();

    // Out-of-range read: error entry, no bus activity.
    rd_push(32'h0100_0000);
    wait_cyc(6);
    chk("rbad_ncmd", cmd_v.size(), 0);
    chk("rbad_valid", R_Valid, 1);
    chk("rbad_err", R_Error, 1);
    chk("rbad_data", R_Data, 0);
    R_Ready = 1'b1;
    @(negedge clk);
    R_Ready = 1'b0;
    chk("rbad_pop", R_Valid, 0);
    clr();

    // Six back-to-back writes: first starts at once, next four fill the FIFO.
    for (int i = 0; i < 6; i++) begin
      d = 32'hA000_0000 + 32'(i) * 32'h0101_0101;
      wr_push((32'(i + 1) << 12) | (32'(i + 8) << 2), d, 4'hF);
      if (i == 4) chk("wready_full", W_Ready, 0);
    end
    wait_cyc(80);
    chk("burst_ncmd", cmd_v.size(), 18);
    for (int i = 0; i < 6; i++) begin
      d = 32'hA000_0000 + 32'(i) * 32'h0101_0101;
      chk_write($sformatf("wb%0d", i), 3 * i, 2 * i, 14'(i + 1), 14'h1000 | 14'(i + 8),
                d[15:0], d[31:16]);
    end
    clr();

    // Partial strobe is discarded.
    wr_push(32'h0000_4567, 32'hDEAD_BEEF, 4'h3);
    wait_cyc(12);
    chk("strb_ncmd", cmd_v.size(), 0);
    chk("strb_nodq", beat_v.size(), 0);
    clr();

    // Reset in the middle of a write burst.
    rd_push(32'h0100_0000);
    wait_cyc(3);
    chk("pre_rst_rvalid", R_Valid, 1);
    wr_push(32'h0000_4567, 32'h1425_3679, 4'hF);
    wait_cyc(5);
    chk("pre_rst_dq", dq, 16'h3679);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_cs", CS, 1);
    chk("mid_rst_ca", CA, 0);
    chk("mid_rst_dq_z", (dq === 16'hzzzz), 1);
    chk("mid_rst_rvalid", R_Valid, 0);
    chk("mid_rst_wready", W_Ready, 1);
    rst_n = 1'b1;
    clr();
    wait_cyc(15);
    chk("post_rst_ncmd", cmd_v.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
